// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: states, instruction classes,
// opcode/funct codes and datapath control encodings.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CLS_ILLEGAL = 4'd0,
      CLS_LW      = 4'd1,
      CLS_SW      = 4'd2,
      CLS_J       = 4'd3,
      CLS_JAL     = 4'd4,
      CLS_BEQ     = 4'd5,
      CLS_BNE     = 4'd6,
      CLS_ADDI    = 4'd7,
      CLS_XORI    = 4'd8,
      CLS_JR      = 4'd9,
      CLS_ADD     = 4'd10,
      CLS_SUB     = 4'd11,
      CLS_SLT     = 4'd12
   } instr_class_e;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_XORI  = 6'h0e;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2b;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2a;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   localparam logic [1:0] PC_INC4 = 2'd0;
   localparam logic [1:0] PC_J    = 2'd1;
   localparam logic [1:0] PC_JR   = 2'd2;
   localparam logic [1:0] PC_BR   = 2'd3;

   localparam logic [1:0] REG_DIN_ALU = 2'd0;
   localparam logic [1:0] REG_DIN_DM  = 2'd1;
   localparam logic [1:0] REG_DIN_JAL = 2'd2;

   localparam logic ALU_B_REG = 1'b0;
   localparam logic ALU_B_IMM = 1'b1;

   localparam logic [1:0] WADDR_RT  = 2'd0;
   localparam logic [1:0] WADDR_RD  = 2'd1;
   localparam logic [1:0] WADDR_R31 = 2'd2;

   function automatic instr_class_e decode_class(input logic [5:0] opc, input logic [5:0] fn);
      instr_class_e cls;
      cls = CLS_ILLEGAL;
      case (opc)
         OPC_LW:   cls = CLS_LW;
         OPC_SW:   cls = CLS_SW;
         OPC_J:    cls = CLS_J;
         OPC_JAL:  cls = CLS_JAL;
         OPC_BEQ:  cls = CLS_BEQ;
         OPC_BNE:  cls = CLS_BNE;
         OPC_ADDI: cls = CLS_ADDI;
         OPC_XORI: cls = CLS_XORI;
         OPC_RTYPE: begin
            case (fn)
               FN_JR:   cls = CLS_JR;
               FN_ADD:  cls = CLS_ADD;
               FN_SUB:  cls = CLS_SUB;
               FN_SLT:  cls = CLS_SLT;
               default: cls = CLS_ILLEGAL;
            endcase
         end
         default:  cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive unanswered memory request cycles; expire is combinational on the
// cycle that would be the WAIT_LIMIT-th unanswered one.
module mem_wait_timer #(
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic busy,
   output logic expire
);

   localparam int unsigned W = $clog2(WAIT_LIMIT);
   localparam logic [W-1:0] LAST = W'(WAIT_LIMIT - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (busy && cnt_q != LAST) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = busy && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB control for the MIPS-subset datapath,
// with memory-wait timeout into a sticky FAULT and a retired-instruction counter.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             aluZero,
   input  logic             memReady,
   output logic             imReq,
   output logic             dmReq,
   output logic             dmWe,
   output logic             irWe,
   output logic             pcWe,
   output logic [1:0]       pcSrcCtrl,
   output logic             regWe,
   output logic [1:0]       regWAddrSel,
   output logic [1:0]       regDInCtrl,
   output logic             aluBSrcCtrl,
   output logic [2:0]       op,
   output logic             retired,
   output logic             illegalInstr,
   output logic             fault,
   output logic [CNT_W-1:0] retireCount
);

   state_e             state_q, state_d;
   instr_class_e       class_q, class_d;
   instr_class_e       decoded;
   logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
   logic [2:0]         cls_op;
   logic               cls_alub;
   logic               tmr_busy, tmr_clear, tmr_expire;

   assign decoded = decode_class(opcode, funct);

   // Request strobes depend on state only, so the timer never sees a combinational loop.
   assign imReq     = (state_q == ST_FETCH) && !reset;
   assign dmReq     = (state_q == ST_MEM) && !reset;
   assign fault     = (state_q == ST_FAULT) && !reset;
   assign tmr_busy  = (imReq || dmReq) && !memReady;
   assign tmr_clear = memReady ||
                      ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM));

   mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .busy   (tmr_busy),
      .expire (tmr_expire)
   );

   // ALU settings per class, shared by EXEC and WB so they stay stable across both.
   always_comb begin
      cls_op   = ALU_ADD;
      cls_alub = ALU_B_REG;
      case (class_q)
         CLS_BEQ, CLS_BNE, CLS_SUB: cls_op = ALU_SUB;
         CLS_SLT:                   cls_op = ALU_SLT;
         CLS_XORI: begin
            cls_op   = ALU_XOR;
            cls_alub = ALU_B_IMM;
         end
         CLS_ADDI, CLS_LW, CLS_SW:  cls_alub = ALU_B_IMM;
         default: begin
            cls_op   = ALU_ADD;
            cls_alub = ALU_B_REG;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      class_d      = class_q;
      irWe         = 1'b0;
      pcWe         = 1'b0;
      pcSrcCtrl    = PC_INC4;
      regWe        = 1'b0;
      regWAddrSel  = WADDR_RT;
      regDInCtrl   = REG_DIN_ALU;
      aluBSrcCtrl  = ALU_B_REG;
      op           = ALU_ADD;
      dmWe         = 1'b0;
      retired      = 1'b0;
      illegalInstr = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            if (memReady) begin
               irWe    = 1'b1;
               pcWe    = 1'b1;
               state_d = ST_DECODE;
            end else if (tmr_expire) begin
               state_d = ST_FAULT;
            end
         end
         ST_DECODE: begin
            class_d = decoded;
            if (decoded == CLS_ILLEGAL) begin
               illegalInstr = 1'b1;
               state_d      = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            op          = cls_op;
            aluBSrcCtrl = cls_alub;
            case (class_q)
               CLS_J, CLS_JAL, CLS_JR: begin
                  pcWe      = 1'b1;
                  pcSrcCtrl = (class_q == CLS_JR) ? PC_JR : PC_J;
                  retired   = 1'b1;
                  state_d   = ST_FETCH;
                  if (class_q == CLS_JAL) begin
                     regWe       = 1'b1;
                     regWAddrSel = WADDR_R31;
                     regDInCtrl  = REG_DIN_JAL;
                  end
               end
               CLS_BEQ, CLS_BNE: begin
                  pcSrcCtrl = PC_BR;
                  pcWe      = (class_q == CLS_BEQ) ? aluZero : !aluZero;
                  retired   = 1'b1;
                  state_d   = ST_FETCH;
               end
               CLS_LW, CLS_SW: state_d = ST_MEM;
               CLS_ADDI, CLS_XORI, CLS_ADD, CLS_SUB, CLS_SLT: state_d = ST_WB;
               default: state_d = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            dmWe = (class_q == CLS_SW);
            if (memReady) begin
               if (class_q == CLS_SW) begin
                  retired = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (tmr_expire) begin
               state_d = ST_FAULT;
            end
         end
         ST_WB: begin
            regWe   = 1'b1;
            retired = 1'b1;
            state_d = ST_FETCH;
            if (class_q == CLS_LW) begin
               regDInCtrl = REG_DIN_DM;
            end else begin
               op          = cls_op;
               aluBSrcCtrl = cls_alub;
               if (class_q == CLS_ADD || class_q == CLS_SUB || class_q == CLS_SLT) begin
                  regWAddrSel = WADDR_RD;
               end
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_FETCH;
      endcase
      if (reset) begin
         irWe         = 1'b0;
         pcWe         = 1'b0;
         pcSrcCtrl    = PC_INC4;
         regWe        = 1'b0;
         regWAddrSel  = WADDR_RT;
         regDInCtrl   = REG_DIN_ALU;
         aluBSrcCtrl  = ALU_B_REG;
         op           = ALU_ADD;
         dmWe         = 1'b0;
         retired      = 1'b0;
         illegalInstr = 1'b0;
      end
   end

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (retired) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         class_q      <= CLS_ILLEGAL;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         class_q      <= class_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retireCount = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: each cycle the expected control strobes come from a phase-list model of
// the instruction sequencing rules, with a wait counter for the memory timeout.
module tb_multicycle_ctrl;

   localparam int LIMIT = 4;
   localparam int CW    = 4;
   localparam int NCYC  = 5000;

   localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_X = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    opcode, funct;
   logic          aluZero, memReady;
   logic          imReq, dmReq, dmWe, irWe, pcWe, regWe, aluBSrcCtrl;
   logic          retired, illegalInstr, fault;
   logic [1:0]    pcSrcCtrl, regWAddrSel, regDInCtrl;
   logic [2:0]    op;
   logic [CW-1:0] retireCount;

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_ctrl #(.WAIT_LIMIT(LIMIT), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct        (funct),
      .aluZero      (aluZero),
      .memReady     (memReady),
      .imReq        (imReq),
      .dmReq        (dmReq),
      .dmWe         (dmWe),
      .irWe         (irWe),
      .pcWe         (pcWe),
      .pcSrcCtrl    (pcSrcCtrl),
      .regWe        (regWe),
      .regWAddrSel  (regWAddrSel),
      .regDInCtrl   (regDInCtrl),
      .aluBSrcCtrl  (aluBSrcCtrl),
      .op           (op),
      .retired      (retired),
      .illegalInstr (illegalInstr),
      .fault        (fault),
      .retireCount  (retireCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // 0 illegal, 1 LW, 2 SW, 3 J, 4 JAL, 5 BEQ, 6 BNE, 7 ADDI, 8 XORI, 9 JR, 10 ADD, 11 SUB, 12 SLT
   function automatic int tb_decode(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'h23: return 1;
         6'h2b: return 2;
         6'h02: return 3;
         6'h03: return 4;
         6'h04: return 5;
         6'h05: return 6;
         6'h08: return 7;
         6'h0e: return 8;
         6'h00: begin
            case (f)
               6'h08:   return 9;
               6'h20:   return 10;
               6'h22:   return 11;
               6'h2a:   return 12;
               default: return 0;
            endcase
         end
         default: return 0;
      endcase
   endfunction

   // {imReq,dmReq,dmWe,irWe,pcWe,pcSrc,regWe,sel,dIn,aluB,op,retired,illegal,fault}
   function automatic logic [18:0] expv(input int ph, input int cls, input bit mr,
                                        input bit az, input bit rst);
      logic im, dm, dwe, ir, pcw, rw, ab, ret, ill, flt;
      logic [1:0] ps, sel, din;
      logic [2:0] o;
      {im, dm, dwe, ir, pcw, rw, ab, ret, ill, flt} = '0;
      ps = 2'd0; sel = 2'd0; din = 2'd0; o = 3'd0;
      if (!rst) begin
         case (ph)
            P_F: begin
               im = 1'b1;
               if (mr) begin ir = 1'b1; pcw = 1'b1; end
            end
            P_D: ill = (cls == 0);
            P_E: begin
               case (cls)
                  3:  begin pcw = 1'b1; ps = 2'd1; ret = 1'b1; end
                  4:  begin pcw = 1'b1; ps = 2'd1; rw = 1'b1; sel = 2'd2; din = 2'd2; ret = 1'b1; end
                  9:  begin pcw = 1'b1; ps = 2'd2; ret = 1'b1; end
                  5:  begin o = 3'd1; ps = 2'd3; pcw = az; ret = 1'b1; end
                  6:  begin o = 3'd1; ps = 2'd3; pcw = !az; ret = 1'b1; end
                  1, 2, 7: ab = 1'b1;
                  8:  begin o = 3'd2; ab = 1'b1; end
                  11: o = 3'd1;
                  12: o = 3'd3;
                  default: ;
               endcase
            end
            P_M: begin
               dm  = 1'b1;
               dwe = (cls == 2);
               ret = mr && (cls == 2);
            end
            P_W: begin
               rw  = 1'b1;
               ret = 1'b1;
               case (cls)
                  1:  din = 2'd1;
                  7:  ab = 1'b1;
                  8:  begin o = 3'd2; ab = 1'b1; end
                  10: sel = 2'd1;
                  11: begin o = 3'd1; sel = 2'd1; end
                  12: begin o = 3'd3; sel = 2'd1; end
                  default: ;
               endcase
            end
            P_X: flt = 1'b1;
            default: ;
         endcase
      end
      return {im, dm, dwe, ir, pcw, ps, rw, sel, din, ab, o, ret, ill, flt};
   endfunction

   logic [5:0] leg_op [12];
   logic [5:0] leg_fn [12];

   initial begin
      int ph, cls, wc, n_ret, fault_cyc, cur_cls;
      logic [18:0] got;
      leg_op = '{6'h23, 6'h2b, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0e, 6'h00, 6'h00, 6'h00, 6'h00};
      leg_fn = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h20, 6'h22, 6'h2a};
      ph = P_F; cls = 0; wc = 0; n_ret = 0; fault_cyc = 0;
      reset = 1'b1; opcode = '0; funct = '0; aluZero = 1'b0; memReady = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         reset    = (cyc < 2) || (fault_cyc >= 3) || ($urandom_range(0, 149) == 0);
         memReady = ($urandom_range(0, 99) < 65);
         aluZero  = $urandom_range(0, 1) == 1;
         if (!reset && ph == P_D) begin
            if ($urandom_range(0, 9) < 7) begin
               int k;
               k = $urandom_range(0, 11);
               opcode = leg_op[k];
               funct  = (leg_op[k] == 6'h00) ? leg_fn[k] : 6'($urandom);
            end else begin
               opcode = 6'($urandom);
               funct  = 6'($urandom);
            end
         end else begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
         end
         #1;
         cur_cls = (ph == P_D) ? tb_decode(opcode, funct) : cls;
         got = {imReq, dmReq, dmWe, irWe, pcWe, pcSrcCtrl, regWe, regWAddrSel, regDInCtrl,
                aluBSrcCtrl, op, retired, illegalInstr, fault};
         chk("strobes", 32'(got), 32'(expv(ph, cur_cls, memReady, aluZero, reset)));
         chk("retireCount", 32'(retireCount), 32'(n_ret % (1 << CW)));

         if (reset) begin
            ph = P_F; wc = 0; n_ret = 0; fault_cyc = 0; cls = 0;
         end else begin
            case (ph)
               P_F: begin
                  if (memReady) begin ph = P_D; wc = 0; end
                  else if (wc == LIMIT - 1) ph = P_X;
                  else wc++;
               end
               P_D: begin
                  cls = cur_cls;
                  if (cls == 0) begin ph = P_F; wc = 0; end
                  else ph = P_E;
               end
               P_E: begin
                  if (cls inside {3, 4, 5, 6, 9}) begin n_ret++; ph = P_F; wc = 0; end
                  else if (cls == 1 || cls == 2) begin ph = P_M; wc = 0; end
                  else ph = P_W;
               end
               P_M: begin
                  if (memReady) begin
                     wc = 0;
                     if (cls == 2) begin n_ret++; ph = P_F; end
                     else ph = P_W;
                  end else if (wc == LIMIT - 1) ph = P_X;
                  else wc++;
               end
               P_W: begin n_ret++; ph = P_F; wc = 0; end
               default: fault_cyc++;
            endcase
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
